// File: rtl/uart_autobaud_pkg.sv
// uart_autobaud_pkg: FSM states and calibration constants shared by the auto-baud detector.
package uart_autobaud_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_HIGH, WAIT_EDGE, MEASURE, DONE} state_t;
    localparam int CAL_EDGES   = 4;
    localparam int ROUND_SHIFT = 3;
endpackage

// File: rtl/uart_autobaud_sync.sv
// uart_autobaud_sync: 2-flop rx synchronizer with falling-edge pulse.
// Defining UART_AUTOBAUD_GLITCH_FILTER_EN adds a 3-sample majority filter (one extra cycle latency).
module uart_autobaud_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_level,
    output logic o_fall
);
    logic r_s1, r_s2, r_prev, w_level;
`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
    logic r_h1, r_h2;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h1 <= 1'b1;
            r_h2 <= 1'b1;
        end else begin
            r_h1 <= r_s2;
            r_h2 <= r_h1;
        end
    end
    assign w_level = (r_s2 & r_h1) | (r_s2 & r_h2) | (r_h1 & r_h2);
`else
    assign w_level = r_s2;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= i_rx;
            r_s2   <= r_s1;
            r_prev <= w_level;
        end
    end
    assign o_level = w_level;
    assign o_fall  = r_prev & ~w_level;
endmodule

// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the bit period of a 0x55 calibration character and reports a UART divisor.
// Optional glitch filter in the synchronizer is enabled by UART_AUTOBAUD_GLITCH_FILTER_EN.
module uart_autobaud
    import uart_autobaud_pkg::*;
#(
    parameter int CNT_WIDTH = 20,
    parameter int MIN_DIV   = 16
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        rx_i,
    input  logic        start_i,
    input  logic        abort_i,
    output logic [15:0] div_o,
    output logic        div_valid_o,
    output logic        busy_o,
    output logic        err_o
);
    state_t               r_state, w_state_n;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_n;
    logic [2:0]           r_edges, w_edges_n;
    logic [15:0]          r_div, w_div_n;
    logic                 r_valid, w_valid_n, r_err, w_err_n;
    logic                 w_level, w_fall, w_d_ok;
    logic [CNT_WIDTH:0]   w_d;

    uart_autobaud_sync u_sync (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_rx    (rx_i),
        .o_level (w_level),
        .o_fall  (w_fall)
    );

    // Count spans 8 bit periods, so divide by 8 rounding to nearest.
    assign w_d    = ({1'b0, r_cnt} + (CNT_WIDTH+1)'(1 << (ROUND_SHIFT - 1))) >> ROUND_SHIFT;
    assign w_d_ok = 64'(w_d) >= 64'(MIN_DIV) && 64'(w_d) <= 64'hFFFF;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_edges_n = r_edges;
        w_div_n   = r_div;
        w_valid_n = 1'b0;
        w_err_n   = r_err;
        if (abort_i) w_state_n = IDLE;
        else begin
            case (r_state)
                IDLE: if (start_i) begin
                    w_state_n = WAIT_HIGH;
                    w_err_n   = 1'b0;
                end
                WAIT_HIGH: if (w_level) w_state_n = WAIT_EDGE;
                WAIT_EDGE: if (w_fall) begin
                    w_state_n = MEASURE;
                    w_cnt_n   = CNT_WIDTH'(1);
                    w_edges_n = 3'd0;
                end
                MEASURE: begin
                    if (w_fall && r_edges == 3'(CAL_EDGES - 1)) w_state_n = DONE;
                    else if (&r_cnt) begin
                        w_state_n = IDLE;
                        w_err_n   = 1'b1;
                    end else begin
                        w_cnt_n   = r_cnt + CNT_WIDTH'(1);
                        w_edges_n = w_fall ? r_edges + 3'd1 : r_edges;
                    end
                end
                DONE: begin
                    w_state_n = IDLE;
                    w_div_n   = w_d_ok ? 16'(w_d) : r_div;
                    w_valid_n = w_d_ok;
                    w_err_n   = r_err | ~w_d_ok;
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_edges <= '0;
            r_div   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_edges <= w_edges_n;
            r_div   <= w_div_n;
            r_valid <= w_valid_n;
            r_err   <= w_err_n;
        end
    end

    assign div_o       = r_div;
    assign div_valid_o = r_valid;
    assign busy_o      = r_state != IDLE;
    assign err_o       = r_err;
endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: randomized scoreboard bench driving a default and a CNT_WIDTH=12 instance in parallel.
module tb_uart_autobaud;
    typedef struct {
        bit          is_err;
        logic [15:0] div;
    } exp_t;

    logic        CLK, RSTN, rx, start, abort;
    logic [15:0] div [2];
    logic        val [2], busy [2], err [2];
    exp_t        q [2][$];
    int          last_div [2];
    bit          lvl [$];
    int          falls [$];
    bit          chk_busy [2], err_d [2];
    int          n_checks = 0, n_pass = 0;

    uart_autobaud u_dut (
        .CLK(CLK), .RSTN(RSTN), .rx_i(rx), .start_i(start), .abort_i(abort),
        .div_o(div[0]), .div_valid_o(val[0]), .busy_o(busy[0]), .err_o(err[0])
    );
    uart_autobaud #(.CNT_WIDTH(12)) u_dut12 (
        .CLK(CLK), .RSTN(RSTN), .rx_i(rx), .start_i(start), .abort_i(abort),
        .div_o(div[1]), .div_valid_o(val[1]), .busy_o(busy[1]), .err_o(err[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, expv);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit raw(input int i);
        return (i < 0) ? 1'b1 : lvl[i];
    endfunction

    // Line level as the edge detector should see it (majority of 3 samples when filtered).
    function automatic bit seen(input int i);
`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
        return (32'(raw(i)) + 32'(raw(i-1)) + 32'(raw(i-2))) >= 2;
`else
        return raw(i);
`endif
    endfunction

    task automatic build_frame(input int p, input bit glitch);
        bit [9:0] fr;
        fr = {1'b1, 8'h55, 1'b0};
        lvl.delete();
        repeat (6) lvl.push_back(1'b1);
        for (int j = 0; j < 10; j++) repeat (p) lvl.push_back(fr[j]);
        repeat (4) lvl.push_back(1'b1);
        if (glitch) lvl[6 + p + p/2] = 1'b0;
    endtask

    task automatic compute_falls();
        bit prev, cur;
        prev = 1'b1;
        falls.delete();
        for (int i = 0; i < lvl.size(); i++) begin
            cur = seen(i);
            if (prev && !cur) falls.push_back(i);
            prev = cur;
        end
    endtask

    task automatic predict();
        int   c, d;
        exp_t e;
        compute_falls();
        if (falls.size() < 5) begin
            check("frame_has_5_falls", falls.size(), 5);
            return;
        end
        c = falls[4] - falls[0];
        d = (c + 4) / 8;
        for (int k = 0; k < 2; k++) begin
            e.is_err = (c >= (1 << (k == 0 ? 20 : 12))) || d < 16 || d > 65535;
            if (!e.is_err) last_div[k] = d;
            e.div = 16'(last_div[k]);
            q[k].push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("busy_after_start", int'(busy[k]), 1);
            check("err_cleared_by_start", int'(err[k]), 0);
        end
    endtask

    task automatic wait_idle_and_drain();
        int n;
        n = 0;
        while ((busy[0] || busy[1]) && n < 2000) begin
            tick();
            n++;
        end
        check("idle_within_bound", int'(n < 2000), 1);
        repeat (3) tick();
        for (int k = 0; k < 2; k++) check("scoreboard_drained", q[k].size(), 0);
    endtask

    task automatic run_frame(input int p, input bit glitch);
        build_frame(p, glitch);
        predict();
        pulse_start();
        foreach (lvl[i]) begin
            rx = lvl[i];
            tick();
        end
        rx = 1'b1;
        wait_idle_and_drain();
    endtask

    always @(negedge CLK) begin : mon
        exp_t e;
        if (RSTN) begin
            for (int k = 0; k < 2; k++) begin
                if (chk_busy[k]) check("busy_low_after_valid", int'(busy[k]), 0);
                chk_busy[k] <= val[k];
                if (val[k]) begin
                    if (q[k].size() == 0) check("unexpected_valid", 1, 0);
                    else begin
                        e = q[k].pop_front();
                        check("expected_valid_not_err", int'(e.is_err), 0);
                        check("div_on_valid", int'(div[k]), int'(e.div));
                    end
                end
                if (err[k] && !err_d[k]) begin
                    if (q[k].size() == 0) check("unexpected_err", 1, 0);
                    else begin
                        e = q[k].pop_front();
                        check("expected_err", int'(e.is_err), 1);
                        check("div_kept_on_err", int'(div[k]), int'(e.div));
                    end
                end
                err_d[k] <= err[k];
            end
        end
    end

    initial begin
        int ab;
        rx = 1'b1; start = 1'b0; abort = 1'b0; RSTN = 1'b0;
        last_div[0] = 0; last_div[1] = 0;
        repeat (3) tick();
        RSTN = 1'b1;
        repeat (2) tick();
        for (int k = 0; k < 2; k++) begin
            check("reset_div", int'(div[k]), 0);
            check("reset_valid", int'(val[k]), 0);
            check("reset_busy", int'(busy[k]), 0);
            check("reset_err", int'(err[k]), 0);
        end

        run_frame(868, 1'b0);
        run_frame(10, 1'b0);
        run_frame(600, 1'b0);

        // Abort after the second falling edge reaches the detector.
        build_frame(200, 1'b0);
        compute_falls();
        ab = falls[1] + 6;
        pulse_start();
        foreach (lvl[i]) begin
            rx = lvl[i];
            abort = (i == ab);
            tick();
            abort = 1'b0;
            if (i == ab)
                for (int k = 0; k < 2; k++) begin
                    check("abort_busy", int'(busy[k]), 0);
                    check("abort_div_kept", int'(div[k]), last_div[k]);
                    check("abort_err_kept", int'(err[k]), 0);
                end
        end
        rx = 1'b1;
        wait_idle_and_drain();

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 2; k++) check("abort_beats_start", int'(busy[k]), 0);

        run_frame(868, 1'b1);

        repeat (5) run_frame(int'($urandom_range(8, 400)), 1'b0);

        // Reset in the middle of a measurement.
        build_frame(300, 1'b0);
        pulse_start();
        for (int i = 0; i < 3 * 300; i++) begin
            rx = lvl[i];
            tick();
        end
        RSTN = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("midreset_div", int'(div[k]), 0);
            check("midreset_busy", int'(busy[k]), 0);
            check("midreset_err", int'(err[k]), 0);
            last_div[k] = 0;
        end
        rx = 1'b1;
        repeat (2) tick();
        RSTN = 1'b1;
        repeat (2) tick();
        run_frame(50, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_autobaud.md
UART_AUTOBAUD -- requirements
Module: uart_autobaud

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 20, width of the bit-period measurement counter.
REQ-002 SHALL have parameter MIN_DIV, default 16, the smallest accepted divisor in clock cycles per bit.
REQ-003 SHALL have port CLK  input  1  the only clock; all flops on its rising edge.
REQ-004 SHALL have port RSTN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port start_i  input  1  one-cycle pulse that arms a measurement.
REQ-007 SHALL have port abort_i  input  1  one-cycle pulse that cancels a measurement.
REQ-008 SHALL have port div_o  output  16  measured clocks-per-bit, formatted for the DLM:DLL divisor pair.
REQ-009 SHALL have port div_valid_o  output  1  one-cycle pulse when div_o is updated.
REQ-010 SHALL have port busy_o  output  1  high while armed or measuring.
REQ-011 SHALL have port err_o  output  1  sticky flag for a failed measurement.

Function
REQ-012 SHALL pass rx_i through a 2-flop synchronizer reset to 1; falling edge = synchronized sample 1 then 0 on consecutive cycles.
REQ-013 SHALL implement FSM states IDLE, WAIT_HIGH, WAIT_EDGE, MEASURE, DONE.
REQ-014 IDLE: start_i -> WAIT_HIGH, clear err_o same edge; start_i in any other state ignored.
REQ-015 WAIT_HIGH: stays until synchronized line is 1 for 1 cycle, then -> WAIT_EDGE (rejects a frame already in progress).
REQ-016 WAIT_EDGE: on falling edge -> MEASURE with counter loaded to 1 and edge count 0.
REQ-017 MEASURE: counter +1 every cycle; each falling edge increments edge count; on 4th edge -> DONE with final count C = cycles between 1st and 5th falling edge (8 bit periods of calibration character 0x55).
REQ-018 DONE: compute D = (C + 4) >> 3; if MIN_DIV <= D <= 16'hFFFF load div_o = D[15:0] and pulse div_valid_o for 1 cycle, else set err_o and leave div_o unchanged; always -> IDLE next cycle.
REQ-019 Counter saturating at all-ones in MEASURE SHALL set err_o and -> IDLE with no div_valid_o.
REQ-020 abort_i in any state SHALL -> IDLE next cycle without touching div_o or err_o; abort_i wins over simultaneous start_i or 4th edge.
REQ-021 busy_o SHALL be 1 in WAIT_HIGH, WAIT_EDGE, MEASURE, DONE; 0 in IDLE.
REQ-022 div_o SHALL hold its last successful value indefinitely.

Reset
REQ-023 RSTN low SHALL force IDLE, div_o=0, div_valid_o=0, busy_o=0, err_o=0, counter/edge count 0, synchronizer flops 1, mid-measurement included.

Configuration
REQ-024 With UART_AUTOBAUD_GLITCH_FILTER_EN defined, SHALL add a 3-sample majority filter after the synchronizer (one extra cycle latency, applied equally to all edges so C is unaffected); edge detection uses filtered value.
REQ-025 Without UART_AUTOBAUD_GLITCH_FILTER_EN, edge detection SHALL use the synchronizer output directly; 1-cycle low glitches count as edges.

Structure
REQ-026 Shared package uart_autobaud_pkg SHALL hold the FSM state enum, calibration edge count (4) and rounding shift (3).
REQ-027 Synchronizer plus optional filter SHALL be sub-module uart_autobaud_sync (outputs filtered level and fall pulse).

Verification
REQ-028 Reset, then idle: all outputs 0, busy_o=0.
REQ-029 start_i, send 0x55 8N1 at 868 cycles/bit -> div_valid_o one pulse, div_o=868, busy_o falls 1 cycle later.
REQ-030 Bit period 10 cycles (D=10 < MIN_DIV) -> err_o=1, no div_valid_o, div_o keeps prior 868; next start_i clears err_o.
REQ-031 abort_i after 2nd falling edge -> IDLE next cycle, div_o and err_o unchanged, no pulse.
REQ-032 CNT_WIDTH=12, bit period 600 cycles -> counter saturates, err_o=1, no pulse.
REQ-033 With UART_AUTOBAUD_GLITCH_FILTER_EN, inject 1-cycle low glitch mid-bit at 868 cycles/bit -> div_o=868; without macro -> wrong div_o or err_o.
